// File: rtl/mod_debounce_pkg.sv
// Shared state encoding and counter sizing for the key debouncer.
package pkg_debounce;

   typedef enum logic [2:0] {S_REL, S_PWAIT, S_PRESS, S_LONG, S_RWAIT} deb_state_t;

   function automatic int cnt_width(input int deb, input int lng);
      int m;
      m = (deb > lng) ? deb : lng;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/mod_debounce_ch.sv
// One key channel: synchroniser, press/release qualification FSM, long-press timer.
// Strobes are registered and appear the cycle after the qualifying tick.
module mod_debounce_ch
   import pkg_debounce::*;
#(
   parameter int DEB_TICKS   = 4,
   parameter int LONG_TICKS  = 200,
   parameter int SYNC_STAGES = 2,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic key_i,
   output logic key_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int             CW     = cnt_width(DEB_TICKS, LONG_TICKS);
   localparam logic [CW-1:0]  DEB_C  = CW'(DEB_TICKS);
   localparam logic [CW-1:0]  LONG_C = CW'(LONG_TICKS);
   localparam logic           POL    = (ACTIVE_LOW != 0);

   logic [SYNC_STAGES-1:0] sync;
   logic                   act;
   deb_state_t             state;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_inc;
   logic                   was_long;

   assign act     = sync[SYNC_STAGES-1] ^ POL;
   assign cnt_inc = cnt + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync      <= {SYNC_STAGES{POL}};
         state     <= S_REL;
         cnt       <= '0;
         was_long  <= 1'b0;
         key_o     <= 1'b0;
         press_o   <= 1'b0;
         release_o <= 1'b0;
         long_o    <= 1'b0;
      end else begin
         sync      <= {sync[SYNC_STAGES-2:0], key_i};
         press_o   <= 1'b0;
         release_o <= 1'b0;
         long_o    <= 1'b0;
         // An act change always takes priority over a tick in the same cycle.
         case (state)
            S_REL: begin
               if (act) begin
                  state <= S_PWAIT;
                  cnt   <= '0;
               end
            end
            S_PWAIT: begin
               if (!act) begin
                  state <= S_REL;
               end else if (tick_i) begin
                  if (cnt_inc == DEB_C) begin
                     state   <= S_PRESS;
                     cnt     <= '0;
                     key_o   <= 1'b1;
                     press_o <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            S_PRESS: begin
               if (!act) begin
                  state    <= S_RWAIT;
                  cnt      <= '0;
                  was_long <= 1'b0;
               end else if (tick_i && (LONG_TICKS != 0)) begin
                  if (cnt_inc == LONG_C) begin
                     state  <= S_LONG;
                     long_o <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            S_LONG: begin
               if (!act) begin
                  state    <= S_RWAIT;
                  cnt      <= '0;
                  was_long <= 1'b1;
               end
            end
            S_RWAIT: begin
               // A release glitch returns to the held state; a long press never refires.
               if (act) begin
                  state <= was_long ? S_LONG : S_PRESS;
                  cnt   <= '0;
               end else if (tick_i) begin
                  if (cnt_inc == DEB_C) begin
                     state     <= S_REL;
                     key_o     <= 1'b0;
                     release_o <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            default: state <= S_REL;
         endcase
      end
   end

endmodule

// File: rtl/mod_debounce.sv
// Multi-channel debouncer: prescaler rising-edge tick shared by N_KEYS channels.
// presc_clk_i is sampled as data; every output is registered inside the channels.
module mod_debounce
   import pkg_debounce::*;
#(
   parameter int N_KEYS      = 4,
   parameter int DEB_TICKS   = 4,
   parameter int LONG_TICKS  = 200,
   parameter int SYNC_STAGES = 2,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              presc_clk_i,
   input  logic [N_KEYS-1:0] key_i,
   output logic [N_KEYS-1:0] key_o,
   output logic [N_KEYS-1:0] press_o,
   output logic [N_KEYS-1:0] release_o,
   output logic [N_KEYS-1:0] long_o
);

   logic presc_q;
   logic tick;

   always_ff @(posedge clk_i) begin
      if (rst_i) presc_q <= 1'b0;
      else       presc_q <= presc_clk_i;
   end

   assign tick = presc_clk_i & ~presc_q;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
      mod_debounce_ch #(
         .DEB_TICKS   (DEB_TICKS),
         .LONG_TICKS  (LONG_TICKS),
         .SYNC_STAGES (SYNC_STAGES),
         .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_ch (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .tick_i    (tick),
         .key_i     (key_i[k]),
         .key_o     (key_o[k]),
         .press_o   (press_o[k]),
         .release_o (release_o[k]),
         .long_o    (long_o[k])
      );
   end

endmodule

// File: tb/tb_mod_debounce.sv
// Bench for mod_debounce: scenario tasks compared cycle by cycle against a tick-counting model.
module tb_mod_debounce;

   localparam int NK  = 4;
   localparam int DEB = 4;
   localparam int LNG = 16;
   localparam int SS  = 2;
   localparam int AL  = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          presc;
   logic [NK-1:0] key;
   logic [NK-1:0] key_o, press_o, release_o, long_o;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int pmode   = 0;   // 0: running prescaler, 1: tied 0, 2: tied 1
   int pcnt    = 0;

   // Reference model: debounced level, ticks seen during a pending change,
   // ticks held since press acceptance, and whether this press already went long.
   logic [SS-1:0] m_sync [NK];
   logic          m_pq;
   int            m_lvl [NK];
   int            m_pend[NK];
   int            m_run [NK];
   int            m_hold[NK];
   int            m_fired[NK];
   logic [NK-1:0] e_key, e_press, e_rel, e_long;

   always #5 clk = ~clk;

   mod_debounce #(
      .N_KEYS(NK), .DEB_TICKS(DEB), .LONG_TICKS(LNG), .SYNC_STAGES(SS), .ACTIVE_LOW(AL)
   ) dut (
      .clk_i(clk), .rst_i(rst), .presc_clk_i(presc), .key_i(key),
      .key_o(key_o), .press_o(press_o), .release_o(release_o), .long_o(long_o)
   );

   task automatic model_reset();
      m_pq = 1'b0;
      e_key = '0; e_press = '0; e_rel = '0; e_long = '0;
      for (int k = 0; k < NK; k++) begin
         m_sync[k] = {SS{(AL != 0)}};
         m_lvl[k] = 0; m_pend[k] = 0; m_run[k] = 0; m_hold[k] = 0; m_fired[k] = 0;
      end
   endtask

   task automatic step();
      logic t, a;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         t = presc & ~m_pq;
         m_pq = presc;
         e_press = '0; e_rel = '0; e_long = '0;
         for (int k = 0; k < NK; k++) begin
            a = m_sync[k][SS-1] ^ (AL != 0);
            m_sync[k] = {m_sync[k][SS-2:0], key[k]};
            if (int'(a) != m_lvl[k]) begin
               if (m_pend[k] == 0) begin
                  m_pend[k] = 1;
                  m_run[k]  = 0;
               end else if (t) begin
                  m_run[k]++;
                  if (m_run[k] == DEB) begin
                     m_lvl[k]  = int'(a);
                     m_pend[k] = 0;
                     if (a) begin
                        e_press[k] = 1'b1; m_hold[k] = 0; m_fired[k] = 0;
                     end else begin
                        e_rel[k] = 1'b1;
                     end
                  end
               end
            end else if (m_pend[k] != 0) begin
               m_pend[k] = 0;
               if (m_lvl[k] == 1) m_hold[k] = 0;
            end else if (m_lvl[k] == 1 && t && LNG != 0 && m_fired[k] == 0) begin
               m_hold[k]++;
               if (m_hold[k] == LNG) begin
                  m_fired[k] = 1; e_long[k] = 1'b1;
               end
            end
            e_key[k] = (m_lvl[k] != 0);
         end
      end
      cyc++;
      @(negedge clk);
      pcnt++;
      presc = (pmode == 0) ? pcnt[2] : (pmode == 2);
   endtask

   task automatic test_reset();
      rst = 1'b1; key = '1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++;
         if ({key_o, press_o, release_o, long_o} !== 16'h0)
            $display("FAIL reset cyc=%0d outputs got %h want 0000", cyc, {key_o, press_o, release_o, long_o});
         else n_pass++;
      end
      rst = 1'b0;
   endtask

   task automatic test_press_release();
      int np = 0, nr = 0;
      key[0] = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         n_total++;
         if ({key_o, press_o, release_o, long_o} !== {e_key, e_press, e_rel, e_long})
            $display("FAIL press cyc=%0d got %h want %h", cyc, {key_o, press_o, release_o, long_o}, {e_key, e_press, e_rel, e_long});
         else n_pass++;
         np += int'(press_o[0]);
      end
      n_total++;
      if (np != 1 || key_o[0] !== 1'b1) $display("FAIL press_once presses=%0d key=%b want 1 and 1", np, key_o[0]);
      else n_pass++;
      key[0] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         n_total++;
         if ({key_o, press_o, release_o, long_o} !== {e_key, e_press, e_rel, e_long})
            $display("FAIL release cyc=%0d got %h want %h", cyc, {key_o, press_o, release_o, long_o}, {e_key, e_press, e_rel, e_long});
         else n_pass++;
         nr += int'(release_o[0]);
      end
      n_total++;
      if (nr != 1 || key_o[0] !== 1'b0) $display("FAIL release_once releases=%0d key=%b want 1 and 0", nr, key_o[0]);
      else n_pass++;
   endtask

   task automatic test_bounce();
      int ns = 0;
      for (int i = 0; i < 240; i++) begin
         key[1] = (i >= 200) ? 1'b1 : (((i / 10) % 2) != 0);
         step();
         n_total++;
         if ({key_o, press_o, release_o, long_o} !== {e_key, e_press, e_rel, e_long})
            $display("FAIL bounce cyc=%0d got %h want %h", cyc, {key_o, press_o, release_o, long_o}, {e_key, e_press, e_rel, e_long});
         else n_pass++;
         ns += int'(press_o[1]) + int'(release_o[1]) + int'(long_o[1]) + int'(key_o[1]);
      end
      n_total++;
      if (ns != 0) $display("FAIL bounce_quiet activity=%0d want 0", ns);
      else n_pass++;
   endtask

   task automatic test_long();
      int np = 0, nl = 0, pc = 0, lc = 0;
      for (int i = 0; i < 260; i++) begin
         key[2] = (i >= 200);
         step();
         n_total++;
         if ({key_o, press_o, release_o, long_o} !== {e_key, e_press, e_rel, e_long})
            $display("FAIL long cyc=%0d got %h want %h", cyc, {key_o, press_o, release_o, long_o}, {e_key, e_press, e_rel, e_long});
         else n_pass++;
         if (press_o[2]) begin np++; pc = cyc; end
         if (long_o[2])  begin nl++; lc = cyc; end
      end
      n_total++;
      if (np != 1 || nl != 1 || (lc - pc) != LNG * 8)
         $display("FAIL long_once presses=%0d longs=%0d gap=%0d want 1 1 %0d", np, nl, lc - pc, LNG * 8);
      else n_pass++;
   endtask

   task automatic test_glitch();
      int nl = 0, nr_early = 0, nr_late = 0;
      for (int i = 0; i < 376; i++) begin
         key[3] = (i >= 200 && i < 216) || (i >= 316);
         step();
         n_total++;
         if ({key_o, press_o, release_o, long_o} !== {e_key, e_press, e_rel, e_long})
            $display("FAIL glitch cyc=%0d got %h want %h", cyc, {key_o, press_o, release_o, long_o}, {e_key, e_press, e_rel, e_long});
         else n_pass++;
         nl += int'(long_o[3]);
         if (i < 316) nr_early += int'(release_o[3]);
         else         nr_late  += int'(release_o[3]);
      end
      n_total++;
      if (nl != 1 || nr_early != 0 || nr_late != 1)
         $display("FAIL glitch_counts longs=%0d early_rel=%0d final_rel=%0d want 1 0 1", nl, nr_early, nr_late);
      else n_pass++;
   endtask

   task automatic test_rst_mid();
      int r = 0, pc = -1, nr = 0;
      key[0] = 1'b0;
      for (int i = 0; i < 50; i++) step();
      n_total++;
      if (key_o[0] !== 1'b1) $display("FAIL rst_pre key0 got %b want 1", key_o[0]);
      else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      r = cyc;
      n_total++;
      if ({key_o, press_o, release_o, long_o} !== 16'h0)
         $display("FAIL rst_mid outputs got %h want 0000", {key_o, press_o, release_o, long_o});
      else n_pass++;
      for (int i = 0; i < 50; i++) begin
         step();
         n_total++;
         if ({key_o, press_o, release_o, long_o} !== {e_key, e_press, e_rel, e_long})
            $display("FAIL repress cyc=%0d got %h want %h", cyc, {key_o, press_o, release_o, long_o}, {e_key, e_press, e_rel, e_long});
         else n_pass++;
         if (press_o[0] && pc < 0) pc = cyc;
         nr += int'(release_o[0]);
      end
      n_total++;
      if (nr != 0 || pc < 0 || (pc - r) < 28 || (pc - r) > 35)
         $display("FAIL repress_timing releases=%0d delay=%0d want 0 and 28..35", nr, pc - r);
      else n_pass++;
      key[0] = 1'b1;
      for (int i = 0; i < 60; i++) step();
   endtask

   task automatic test_stuck_and_simul();
      int ns = 0, p0 = -1, p3 = -2;
      for (int m = 1; m <= 2; m++) begin
         pmode = m;
         for (int i = 0; i < 150; i++) begin
            if (i % 5 == 0) key = NK'($urandom);
            step();
            n_total++;
            if ({key_o, press_o, release_o, long_o} !== {e_key, e_press, e_rel, e_long})
               $display("FAIL stuck cyc=%0d got %h want %h", cyc, {key_o, press_o, release_o, long_o}, {e_key, e_press, e_rel, e_long});
            else n_pass++;
            ns += $countones({press_o, release_o, long_o, key_o});
         end
      end
      n_total++;
      if (ns != 0) $display("FAIL stuck_quiet activity=%0d want 0", ns);
      else n_pass++;
      key = '1; pmode = 0;
      for (int i = 0; i < 60; i++) step();
      key[0] = 1'b0; key[3] = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         n_total++;
         if ({key_o, press_o, release_o, long_o} !== {e_key, e_press, e_rel, e_long})
            $display("FAIL simul cyc=%0d got %h want %h", cyc, {key_o, press_o, release_o, long_o}, {e_key, e_press, e_rel, e_long});
         else n_pass++;
         if (press_o[0]) p0 = cyc;
         if (press_o[3]) p3 = cyc;
      end
      n_total++;
      if (p0 != p3) $display("FAIL simul_press ch0 cyc=%0d ch3 cyc=%0d want equal", p0, p3);
      else n_pass++;
      key = '1;
      for (int i = 0; i < 60; i++) step();
   endtask

   task automatic test_random();
      int rem[NK];
      for (int k = 0; k < NK; k++) rem[k] = 1;
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NK; k++) begin
            rem[k]--;
            if (rem[k] <= 0) begin
               key[k] = ~key[k];
               rem[k] = ($urandom_range(0, 7) == 0) ? $urandom_range(130, 220) : $urandom_range(1, 45);
            end
         end
         step();
         n_total++;
         if ({key_o, press_o, release_o, long_o} !== {e_key, e_press, e_rel, e_long})
            $display("FAIL random cyc=%0d got %h want %h", cyc, {key_o, press_o, release_o, long_o}, {e_key, e_press, e_rel, e_long});
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; presc = 1'b0; key = '1;
      model_reset();
      test_reset();
      test_press_release();
      test_bounce();
      test_long();
      test_glitch();
      test_rst_mid();
      test_stuck_and_simul();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
